// File: rtl/uart_rx.sv
// 8N1 serial receiver driven by a 16x oversample tick; realigns the tick source
// via start_rx and delivers bytes on a valid/ack handshake with error flags.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SAMPLE_RATE = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 tick,
  output logic                 start_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  // state | meaning
  // IDLE  | line idle, waiting for a falling edge on rx_s
  // START | counting to mid start bit to reject glitches
  // DATA  | sampling payload bits at mid-bit, LSB first
  // STOP  | sampling stop bit, then completion
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int TW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(SAMPLE_RATE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_hist;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop;
  logic                 r_done;
  logic                 r_start_rx;
  logic                 r_busy;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_data_valid;
  logic                 r_framing_error;
  logic                 r_overrun;
  logic                 w_fall;

  assign w_fall = r_hist & ~r_sync2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_hist     <= 1'b1;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_stop     <= 1'b1;
      r_done     <= 1'b0;
      r_start_rx <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_hist     <= r_sync2;
      r_start_rx <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_start_rx <= 1'b1;
            r_tick_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (r_tick_cnt == TICK_HALF) begin
              if (!r_sync2) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
                r_state    <= S_DATA;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == TICK_LAST) begin
              r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == BIT_LAST)
                r_state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == TICK_LAST) begin
              r_stop  <= r_sync2;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A completion always wins over an ack; the ack only decides whether overrun sets.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data          <= '0;
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else if (r_done) begin
      r_data          <= r_shift;
      r_framing_error <= ~r_stop;
      r_data_valid    <= 1'b1;
      if (r_data_valid)
        r_overrun <= ~data_ack;
    end else if (r_data_valid && data_ack) begin
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign start_rx      = r_start_rx;
  assign busy          = r_busy;
  assign data          = r_data;
  assign data_valid    = r_data_valid;
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: models a divide-by-10 tick source realigned by start_rx and
// scoreboards expected bytes against each completion.
module tb_uart_rx;

  localparam int DIV      = 10;
  localparam int SR       = 16;
  localparam int BIT_CLKS = DIV * SR;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       tick;
  logic       start_rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack;
  logic       framing_error;
  logic       overrun;
  logic       busy;
  logic       ack_main = 1'b0;
  logic       ack_mon = 1'b0;
  logic       ack_on_done = 1'b0;
  logic [3:0] r_div;

  typedef struct {
    logic       deliver;
    logic [7:0] data;
    logic       fe;
    logic       ovr;
    logic       valid;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   start_cnt = 0;
  int   s0;

  uart_rx #(.DATA_BITS(8), .SAMPLE_RATE(SR)) dut (
    .clock(clock), .reset_n(reset_n), .rx(rx), .tick(tick),
    .start_rx(start_rx), .data(data), .data_valid(data_valid),
    .data_ack(data_ack), .framing_error(framing_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;
  assign data_ack = ack_main | ack_mon;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_div <= '0;
    else if (start_rx || r_div == 4'(DIV - 1)) r_div <= '0;
    else r_div <= r_div + 1'b1;
  end
  assign tick = (r_div == 4'(DIV - 1));

  always @(negedge clock) if (start_rx) start_cnt++;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic fe, input logic ovr);
    exp_t e;
    e.deliver = 1'b1; e.data = b; e.fe = fe; e.ovr = ovr; e.valid = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic expect_none();
    exp_t e;
    e.deliver = 1'b0; e.data = 8'h00; e.fe = 1'b0; e.ovr = 1'b0; e.valid = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic do_ack(input logic [7:0] d);
    ack_main = 1'b1;
    @(negedge clock);
    ack_main = 1'b0;
    chk_eq("ack_valid", 32'(data_valid), 32'd0);
    chk_eq("ack_data", 32'(data), 32'(d));
    chk_eq("ack_overrun", 32'(overrun), 32'd0);
  endtask

  // Completion monitor: busy falls at the stop/false-start sample, outputs settle one cycle later.
  initial begin
    logic pb;
    exp_t e;
    pb = 1'b0;
    forever begin
      @(negedge clock);
      if (pb && !busy) begin
        if (ack_on_done) ack_mon = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ack_mon = 1'b0;
        chk_eq("sb_pending", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          if (e.deliver) begin
            chk_eq("rx_data", 32'(data), 32'(e.data));
            chk_eq("rx_framing", 32'(framing_error), 32'(e.fe));
          end
          chk_eq("rx_valid", 32'(data_valid), 32'(e.valid));
          chk_eq("rx_overrun", 32'(overrun), 32'(e.ovr));
        end
      end
      pb = busy;
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    chk_eq("rst_data", 32'(data), 32'd0);
    chk_eq("rst_valid", 32'(data_valid), 32'd0);
    chk_eq("rst_fe", 32'(framing_error), 32'd0);
    chk_eq("rst_ovr", 32'(overrun), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_start", 32'(start_rx), 32'd0);
    reset_n = 1'b1;
    idle(20);

    s0 = start_cnt;
    expect_byte(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1);
    idle(40);
    chk_eq("nom_starts", 32'(start_cnt - s0), 32'd1);
    chk_eq("nom_busy", 32'(busy), 32'd0);
    chk_eq("nom_drained", 32'(sb_q.size()), 32'd0);
    do_ack(8'hA5);

    s0 = start_cnt;
    expect_none();
    rx = 1'b0;
    repeat (3 * DIV) @(negedge clock);
    idle(200);
    chk_eq("glitch_starts", 32'(start_cnt - s0), 32'd1);
    chk_eq("glitch_valid", 32'(data_valid), 32'd0);
    chk_eq("glitch_drained", 32'(sb_q.size()), 32'd0);

    s0 = start_cnt;
    expect_byte(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0);
    send_bit(1'b0);
    chk_eq("break_starts", 32'(start_cnt - s0), 32'd1);
    idle(40);
    chk_eq("fe_drained", 32'(sb_q.size()), 32'd0);
    do_ack(8'h3C);
    expect_byte(8'h00, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1);
    idle(40);
    chk_eq("after_fe_drained", 32'(sb_q.size()), 32'd0);
    do_ack(8'h00);

    expect_byte(8'h11, 1'b0, 1'b0);
    expect_byte(8'h22, 1'b0, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(40);
    chk_eq("ovr_drained", 32'(sb_q.size()), 32'd0);
    do_ack(8'h22);

    expect_byte(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1);
    ack_on_done = 1'b1;
    expect_byte(8'h22, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1);
    idle(40);
    ack_on_done = 1'b0;
    chk_eq("ackdone_drained", 32'(sb_q.size()), 32'd0);
    do_ack(8'h22);

    s0 = start_cnt;
    expect_none();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * BIT_CLKS + 80) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_eq("midrst_data", 32'(data), 32'd0);
        chk_eq("midrst_valid", 32'(data_valid), 32'd0);
        chk_eq("midrst_busy", 32'(busy), 32'd0);
        chk_eq("midrst_fe", 32'(framing_error), 32'd0);
        chk_eq("midrst_ovr", 32'(overrun), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
      end
    join
    idle(40);
    chk_eq("midrst_starts", 32'(start_cnt - s0), 32'd1);
    chk_eq("midrst_drained", 32'(sb_q.size()), 32'd0);

    expect_byte(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1);
    idle(40);
    chk_eq("final_drained", 32'(sb_q.size()), 32'd0);
    do_ack(8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive stage that sits directly downstream of baud_rate_generator and consumes its 16x oversample `tick`.
- Detects the start bit and drives `start_rx` back into the generator so the tick phase realigns to the falling edge.
- Samples 8N1 frames at mid-bit, LSB first, and presents each received byte on a valid/ack handshake.
- Reports framing and overrun errors.

Parameters:
- DATA_BITS, 8, payload bits per frame (LSB first).
- SAMPLE_RATE, 16, ticks per bit period. Must match the generator; must be a power of 2, ≥4.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- tick  input  1  one-cycle oversample strobe from baud_rate_generator.
- start_rx  output  1  one-cycle pulse on start-edge detect. Wired to the generator's start_rx.
- data  output  DATA_BITS  last received byte.
- data_valid  output  1  `data` holds an unconsumed byte.
- data_ack  input  1  consumer accepts `data`. Only meaningful while data_valid=1.
- framing_error  output  1  stop bit of the byte in `data` was sampled 0.
- overrun  output  1  sticky: a byte was overwritten before ack.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - FSM goes to IDLE.
  - Synchronizer flops and the edge-detect history flop go to 1.
  - Tick counter and bit counter clear to 0.
  - data=0; data_valid, framing_error, overrun, start_rx and busy all 0.
  - Reset mid-frame abandons the frame; no partial byte is ever presented.
- Synchronizer: rx passes through 2 flops to give rx_s. Edge detect uses rx_s and a third (history) flop.
- IDLE:
  - A falling edge (history=1, rx_s=0) pulses start_rx for exactly one cycle and moves to START with tick_cnt=0.
  - A line held low never retriggers; a new edge requires rx_s to return to 1.
- START:
  - Count ticks. On the tick with tick_cnt=SAMPLE_RATE/2-1 (mid start bit), sample rx_s.
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1: false start (glitch). Return to IDLE with no output change.
- DATA:
  - On each tick with tick_cnt=SAMPLE_RATE-1, shift rx_s into the MSB of the shift register (shift right) and increment bit_cnt. tick_cnt wraps to 0.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - On the tick with tick_cnt=SAMPLE_RATE-1, sample the stop bit, then return to IDLE on the next cycle.
  - Completion: data ← shift register, data_valid ← 1, framing_error ← (stop sample==0). All update on the cycle after the stop-sample tick edge (1-cycle registered latency).
  - A byte with a bad stop bit is still delivered, with framing_error=1.
  - After a 0 stop bit, IDLE waits for rx_s high before the next edge can be detected (break condition).
- Counting rules:
  - Ticks are counted only when tick=1.
  - tick_cnt width is clog2(SAMPLE_RATE); bit_cnt width is clog2(DATA_BITS)+1.
  - start_rx is not asserted again during a frame.
- Handshake:
  - data_valid stays high until data_ack=1 is seen in a cycle with data_valid=1. That clears data_valid and overrun; data stays unchanged.
  - Completion while data_valid=1 with no ack in the same cycle: data and framing_error are overwritten, data_valid stays 1, overrun ← 1. overrun is sticky until ack.
  - Completion and ack in the same cycle: the new byte is loaded, data_valid stays 1, overrun=0.
  - data_ack while data_valid=0 is ignored.
- busy = (state != IDLE).

Test Plan:
- Nominal byte: generator at CLK_HZ=1536000, BAUD_RATE=9600 (DIVISOR=10), frame 0xA5 with stop=1.
  - start_rx pulses exactly once.
  - data=0xA5, data_valid=1, framing_error=0 one cycle after the stop sample.
  - busy returns to 0.
  - Ack → data_valid=0, data still 0xA5.
- Glitch: rx low for 3 ticks then high.
  - start_rx pulses once, FSM returns to IDLE from START.
  - data_valid stays 0, no byte delivered.
- Framing error: frame 0x3C with stop bit 0, rx held low 2 bit times, then high.
  - data=0x3C, data_valid=1, framing_error=1.
  - No second start_rx while the line is low.
  - Next frame 0x00 with good stop is received normally.
- Overrun: frames 0x11 then 0x22 back-to-back, no ack.
  - After the second frame: data=0x22, data_valid=1, overrun=1.
  - Ack clears both flags.
  - Repeat with the ack on the exact completion cycle → data=0x22, data_valid=1, overrun=0.
- Reset mid-frame: reset_n low for 1 cycle during bit 4 of frame 0xFF.
  - All outputs 0 immediately (asynchronous).
  - The remainder of the frame is ignored until rx idles high.
  - Next frame 0x5A is received correctly.
